// File: rtl/axi_build_info_pkg.sv
// rtl/axi_build_info_pkg.sv - shared constants and FSM state types for axi_build_info
package axi_build_info_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Word indices (byte address >> 2)
    localparam int IDX_MAJOR       = 0;
    localparam int IDX_MINOR       = 1;
    localparam int IDX_BUILD       = 2;
    localparam int IDX_RCAND       = 3;
    localparam int IDX_DATE        = 4;
    localparam int IDX_RTL_TYPE    = 5;
    localparam int IDX_RTL_SUBTYPE = 6;
    localparam int IDX_SCRATCH     = 7;
    localparam int IDX_UPTIME      = 8;
    localparam int IDX_CAPS        = 9;
    localparam int HASH_BASE_IDX   = 16;

    localparam logic [7:0] CAPS_FEATURES = 8'h03;

    typedef enum logic {R_IDLE, R_RESP} rd_state_e;
    typedef enum logic {W_COLLECT, W_RESP} wr_state_e;

endpackage

// File: rtl/axi_build_info_uptime_counter.sv
// rtl/axi_build_info_uptime_counter.sv - clock prescaler driving a 32-bit seconds counter
module uptime_counter #(
    parameter int CLK_FREQ_HZ = 250000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] uptime_sec
);

    localparam int PRE_W = $clog2(CLK_FREQ_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);

    logic [PRE_W-1:0] prescaler;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            uptime_sec <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler  <= '0;
            uptime_sec <= uptime_sec + 32'd1;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

endmodule

// File: rtl/axi_build_info.sv
// rtl/axi_build_info.sv - AXI4-Lite slave reporting build identity, scratch, uptime and caps
module axi_build_info
    import axi_build_info_pkg::*;
#(
    parameter int                       AXI_ADDR_WIDTH = 8,
    parameter int                       HASH_WORDS     = 5,
    parameter int                       CLK_FREQ_HZ    = 250000000,
    parameter logic [31:0]              VERSION_MAJOR  = 32'd0,
    parameter logic [31:0]              VERSION_MINOR  = 32'd0,
    parameter logic [31:0]              VERSION_BUILD  = 32'd0,
    parameter logic [31:0]              VERSION_RCAND  = 32'd0,
    parameter logic [31:0]              VERSION_DATE   = 32'd0,
    parameter logic [31:0]              RTL_TYPE       = 32'd0,
    parameter logic [31:0]              RTL_SUBTYPE    = 32'd0,
    parameter logic [HASH_WORDS*32-1:0] GIT_HASH       = '0
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic [31:0]               S_AXI_WDATA,
    input  logic [3:0]                S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    input  logic [2:0]                S_AXI_ARPROT,
    output logic [31:0]               S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY
);

    localparam int IDXW = AXI_ADDR_WIDTH - 2;

    rd_state_e        rd_state, rd_state_d;
    wr_state_e        wr_state, wr_state_d;
    logic [IDXW-1:0]  ar_idx, aw_idx;
    logic [31:0]      rd_mux, scratch, uptime_sec, wdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       rd_resp_d, wr_resp_d;
    logic             ar_hs, aw_hs, w_hs, aw_held, w_held, wr_commit;
    logic             unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic idx_mapped(input logic [IDXW-1:0] idx);
        return (idx <= IDXW'(IDX_CAPS)) ||
               ((idx >= IDXW'(HASH_BASE_IDX)) && (idx < IDXW'(HASH_BASE_IDX + HASH_WORDS)));
    endfunction

    uptime_counter #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_uptime (
        .clk        (AXI_ACLK),
        .rst_n      (AXI_ARESETN),
        .uptime_sec (uptime_sec)
    );

    // Handshake readiness is a pure function of state so an async reset drops VALIDs at once
    assign S_AXI_ARREADY = (rd_state == R_IDLE);
    assign S_AXI_RVALID  = (rd_state == R_RESP);
    assign S_AXI_AWREADY = (wr_state == W_COLLECT) && !aw_held;
    assign S_AXI_WREADY  = (wr_state == W_COLLECT) && !w_held;
    assign S_AXI_BVALID  = (wr_state == W_RESP);

    assign ar_idx = S_AXI_ARADDR[AXI_ADDR_WIDTH-1:2];
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;

    always_comb begin
        rd_mux    = '0;
        rd_resp_d = RESP_OKAY;
        case (ar_idx)
            IDXW'(IDX_MAJOR):       rd_mux = VERSION_MAJOR;
            IDXW'(IDX_MINOR):       rd_mux = VERSION_MINOR;
            IDXW'(IDX_BUILD):       rd_mux = VERSION_BUILD;
            IDXW'(IDX_RCAND):       rd_mux = VERSION_RCAND;
            IDXW'(IDX_DATE):        rd_mux = VERSION_DATE;
            IDXW'(IDX_RTL_TYPE):    rd_mux = RTL_TYPE;
            IDXW'(IDX_RTL_SUBTYPE): rd_mux = RTL_SUBTYPE;
            IDXW'(IDX_SCRATCH):     rd_mux = scratch;
            IDXW'(IDX_UPTIME):      rd_mux = uptime_sec;
            IDXW'(IDX_CAPS):        rd_mux = {16'h0, 8'(HASH_WORDS), CAPS_FEATURES};
            default:                rd_resp_d = RESP_DECERR;
        endcase
        // Hash word 0 is the most-significant slice of GIT_HASH
        for (int i = 0; i < HASH_WORDS; i++) begin
            if (ar_idx == IDXW'(HASH_BASE_IDX + i)) begin
                rd_mux    = GIT_HASH[(HASH_WORDS-1-i)*32 +: 32];
                rd_resp_d = RESP_OKAY;
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state;
        case (rd_state)
            R_IDLE: if (ar_hs) rd_state_d = R_RESP;
            R_RESP: if (S_AXI_RREADY) rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            rd_state    <= R_IDLE;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_d;
            if (ar_hs) begin
                S_AXI_RDATA <= rd_mux;
                S_AXI_RRESP <= rd_resp_d;
            end
        end
    end

    always_comb begin
        wr_state_d = wr_state;
        wr_commit  = 1'b0;
        if (aw_idx == IDXW'(IDX_SCRATCH)) wr_resp_d = RESP_OKAY;
        else if (idx_mapped(aw_idx))      wr_resp_d = RESP_SLVERR;
        else                              wr_resp_d = RESP_DECERR;
        case (wr_state)
            W_COLLECT: if (aw_held && w_held) begin
                wr_commit  = 1'b1;
                wr_state_d = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) wr_state_d = W_COLLECT;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            wr_state    <= W_COLLECT;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            scratch     <= '0;
            S_AXI_BRESP <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_d;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_commit) begin
                S_AXI_BRESP <= wr_resp_d;
                if (wr_resp_d == RESP_OKAY) begin
                    for (int k = 0; k < 4; k++) begin
                        if (wstrb_q[k]) scratch[8*k +: 8] <= wdata_q[8*k +: 8];
                    end
                end
            end
            if ((wr_state == W_RESP) && S_AXI_BREADY) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_build_info.sv
// tb/tb_axi_build_info.sv - directed self-checking bench for axi_build_info
module tb_axi_build_info;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] d;
    logic [1:0]  r;

    always #5 clk = ~clk;

    axi_build_info #(
        .AXI_ADDR_WIDTH (8),
        .HASH_WORDS     (5),
        .CLK_FREQ_HZ    (10),
        .VERSION_MAJOR  (32'd3),
        .VERSION_MINOR  (32'd7),
        .VERSION_BUILD  (32'd42),
        .VERSION_RCAND  (32'd1),
        .VERSION_DATE   (32'h0C1F07E8),
        .RTL_TYPE       (32'h0000ABCD),
        .RTL_SUBTYPE    (32'h00000002),
        .GIT_HASH       (160'h11111111_22222222_33333333_44444444_55555555)
    ) dut (
        .AXI_ACLK      (clk),
        .AXI_ARESETN   (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] dout, output logic [1:0] rout);
        logic hs;
        hs      = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 20 && !hs; n++) begin
            hs = arready;
            step();
        end
        arvalid = 1'b0;
        check("ar_handshake", 32'(hs), 32'd1);
        check("rvalid_latency", 32'(rvalid), 32'd1);
        dout   = rdata;
        rout   = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("rvalid_clear", 32'(rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] dat, input logic [3:0] s,
                            output logic [1:0] rout);
        logic aw_done, w_done;
        aw_done = 1'b0;
        w_done  = 1'b0;
        awaddr  = a;
        wdata   = dat;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            if (awready) aw_done = 1'b1;
            if (wready)  w_done  = 1'b1;
            step();
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_handshake", 32'({aw_done, w_done}), 32'd3);
        step();
        check("bvalid_latency", 32'(bvalid), 32'd1);
        rout   = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bvalid_clear", 32'(bvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; bready = 0;
        arvalid = 0; rready = 0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        step();
        check("rst_ready", 32'({awready, wready, arready}), 32'd7);
        check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_resp_data", {rdata[29:0], bresp} | 32'(rresp), 32'd0);
        step();
        rst_n = 1'b1;

        do_read(8'h00, d, r); check("major", d, 32'd3); check("major_resp", 32'(r), 32'd0);
        do_read(8'h24, d, r); check("caps", d, 32'h00000503);
        do_read(8'h10, d, r); check("date", d, 32'h0C1F07E8);
        do_read(8'h40, d, r); check("hash0", d, 32'h11111111);
        do_read(8'h43, d, r); check("hash0_lowbits", d, 32'h11111111);
        do_read(8'h50, d, r); check("hash4", d, 32'h55555555); check("hash4_resp", 32'(r), 32'd0);
        do_read(8'h54, d, r); check("hash5_data", d, 32'd0); check("hash5_resp", 32'(r), 32'd3);
        do_read(8'h28, d, r); check("gap_resp", 32'(r), 32'd3);

        do_write(8'h1C, 32'hDEADBEEF, 4'hF, r); check("scr_w1_resp", 32'(r), 32'd0);
        do_write(8'h1C, 32'h00000000, 4'b0101, r); check("scr_w2_resp", 32'(r), 32'd0);
        do_read(8'h1C, d, r); check("scr_strobe", d, 32'hDE00BE00);

        // W leads AW by three cycles
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("wlead_ready", 32'({awready, wready}), 32'd2);
        step(); step();
        check("wlead_nob", 32'(bvalid), 32'd0);
        awaddr = 8'h1C; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("wlead_aw_taken", 32'({awready, bvalid}), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("wlead_b_stall", 32'({bvalid, bresp}), 32'd4);
            step();
        end
        bready = 1'b1; step(); bready = 1'b0;
        check("wlead_release", 32'({awready, wready, bvalid}), 32'd6);

        // AW, W and AR of scratch in the same cycle with both responses stalled
        awaddr = 8'h1C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 8'h1C; arvalid = 1;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("same_r_early", 32'({rvalid, bvalid}), 32'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            check("same_r_stall", rdata, 32'h12345678);
            check("same_vld_stall", 32'({rvalid, bvalid, rresp, bresp}), 32'h30);
            step();
        end
        rready = 1; bready = 1; step(); rready = 0; bready = 0;
        check("same_release", 32'({rvalid, bvalid}), 32'd0);
        do_read(8'h1C, d, r); check("same_scr", d, 32'hCAFEF00D);

        do_write(8'h00, 32'hFFFFFFFF, 4'hF, r); check("wr_major_slverr", 32'(r), 32'd2);
        do_read(8'h00, d, r); check("major_unchanged", d, 32'd3);
        do_write(8'h20, 32'h1, 4'hF, r); check("wr_uptime_slverr", 32'(r), 32'd2);
        do_write(8'h50, 32'h1, 4'hF, r); check("wr_hash4_slverr", 32'(r), 32'd2);
        do_write(8'h54, 32'h1, 4'hF, r); check("wr_hash5_decerr", 32'(r), 32'd3);
        do_write(8'h7C, 32'h1, 4'hF, r); check("wr_7c_decerr", 32'(r), 32'd3);
        do_read(8'h1C, d, r); check("scr_after_errs", d, 32'hCAFEF00D);

        // Read handshake lands on the write-commit edge
        awaddr = 8'h1C; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0; araddr = 8'h1C; arvalid = 1;
        step();
        arvalid = 0;
        check("commit_edge_rd", rdata, 32'hCAFEF00D);
        check("commit_edge_vld", 32'({rvalid, bvalid}), 32'd3);
        rready = 1; bready = 1; step(); rready = 0; bready = 0;
        do_read(8'h1C, d, r); check("commit_edge_new", d, 32'h0BADF00D);

        // Uptime: 35 edges after release at 10 clocks per second
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        do_read(8'h20, d, r); check("uptime_35", d, 32'd3);
        do_read(8'h1C, d, r); check("scr_reset", d, 32'd0);

        // Async reset while RVALID is pending
        araddr = 8'h20; arvalid = 1;
        step();
        arvalid = 0;
        check("mid_rvalid", 32'(rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rvalid_drop", 32'({rvalid, arready}), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        check("no_resp_after_rst", 32'(rvalid), 32'd0);
        do_read(8'h20, d, r); check("uptime_post_rst", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
